example: RTL and testbench

EXAMPLE -- requirements
Module: example

---
 rtl/example.sv | 138 +++++++++++++
 tb/tb_example.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/example.sv
// ---------------------------------------------------------------------------
// example -- synchronous single-clock FIFO with a registered read port.
//
// Words are returned in the order they were written. A write is taken on a
// rising edge when wr_en=1 and the FIFO is not full; a read is taken when
// rd_en=1 and the FIFO is not empty. Both decisions use the flag values held
// before the edge. A taken read loads rd_data one cycle later, and rd_data
// holds its value on every other cycle. When both requests arrive while
// full, only the read is taken. When both requests arrive while empty, only
// the write is taken.
//
// Parameters:
//   DATA_W  data word width in bits                (default 8)
//   DEPTH   number of entries, power of two, >= 2  (default 16)
//
// Ports:
//   clk        in   single clock, rising-edge active
//   rst        in   synchronous active-high reset, overrides wr_en/rd_en
//   wr_en      in   write request
//   wr_data    in   write data, DATA_W bits
//   rd_en      in   read request
//   rd_data    out  registered read data, DATA_W bits
//   full       out  registered, high when count == DEPTH
//   empty      out  registered, high when count == 0
//   count      out  registered occupancy, clog2(DEPTH)+1 bits
//   overflow   out  sticky: wr_en seen while full   (EXAMPLE_STATUS_EN only)
//   underflow  out  sticky: rd_en seen while empty  (EXAMPLE_STATUS_EN only)
//
// Build option:
//   EXAMPLE_STATUS_EN  when defined, adds the sticky overflow/underflow
//                      outputs. When undefined, the ports and their logic
//                      are absent.
// ---------------------------------------------------------------------------
module example #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
`ifdef EXAMPLE_STATUS_EN
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Occupancy value that means "full", sized to the count register.
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              wr_acc;
    logic              rd_acc;

    // The registered flags gate acceptance. A write while full is dropped
    // even when a read is taken on the same edge. A read while empty is
    // dropped even when a write is taken on the same edge.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // NOTE: combinational logic uses blocking '=' with a default assignment
    // first, so every path assigns count_next and no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: storage has no reset. The pointers are reset instead, so stale
    // words left from before a reset can never be addressed for reading.
    // Leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, read data and status. The pointers wrap naturally because
    // DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking '<=', so every register in
    // this block samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            count <= count_next;
            // Flags are decoded from the next count. They change on the
            // same edge as the operation, yet stay plain registers.
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

`ifdef EXAMPLE_STATUS_EN
    // Sticky error flags record any request made against the current
    // flags, including dropped requests. Only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_example.sv
// ---------------------------------------------------------------------------
// tb_example -- self-checking bench for the example FIFO.
//
// A queue-based reference model predicts occupancy, flags, read data and
// sticky status after every clock edge. Directed scenarios cover reset,
// fill/drain, both requests while full, both requests while empty, pointer
// wrap, and mid-stream reset. A randomized phase follows the directed ones.
// ---------------------------------------------------------------------------
module tb_example;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              wr_en   = 1'b0;
    logic              rd_en   = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
`ifdef EXAMPLE_STATUS_EN
    logic              overflow;
    logic              underflow;
`endif

    example #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
`ifdef EXAMPLE_STATUS_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: contents held in write order, plus the last read word.
    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] model_rd = '0;
    bit                model_ov = 1'b0;
    bit                model_un = 1'b0;
    int                max_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " count"}, 32'(count), 32'(model_q.size()));
        check({tag, " full"},  32'(full),  32'(model_q.size() == DEPTH));
        check({tag, " empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, " rd_data"}, 32'(rd_data), 32'(model_rd));
`ifdef EXAMPLE_STATUS_EN
        check({tag, " overflow"},  32'(overflow),  32'(model_ov));
        check({tag, " underflow"}, 32'(underflow), 32'(model_un));
`endif
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    // Apply one cycle of stimulus, advance the model by the FIFO rules, then
    // compare all outputs 1 time unit after the edge.
    task automatic step(input bit we, input logic [DATA_W-1:0] wd, input bit re,
                        input string tag);
        bit was_full;
        bit was_empty;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        @(posedge clk);
        if (re && !was_empty) model_rd = model_q.pop_front();
        if (we && !was_full)  model_q.push_back(wd);
        if (we && was_full)   model_ov = 1'b1;
        if (re && was_empty)  model_un = 1'b1;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        model_q.delete();
        model_rd = '0;
        model_ov = 1'b0;
        model_un = 1'b0;
        #1;
        rst = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int wr_done;
        int rd_done;
        int budget;
        bit we;
        bit re;

        // Reset, then idle.
        do_reset("reset");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "idle");

        // Fill with 0x11..0x20, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'h11 + i), 1'b0, "fill");
        check("filled count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, "drain");
            check("drain order", 32'(rd_data), 32'(8'h11 + i));
        end
        check("drained empty", 32'(empty), 32'd1);

        // Full, then both requests with 0xAA: read taken, write dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'h40 + i), 1'b0, "refill");
        step(1'b1, 8'hAA, 1'b1, "full both");
        check("full both count", 32'(count), 32'd15);
        check("full both oldest", 32'(rd_data), 32'h40);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, "drain after drop");
        check("no 0xAA stored", 32'(rd_data), 32'h4F);

        // Empty, then both requests with 0x5C: write taken, read dropped.
        step(1'b1, 8'h5C, 1'b1, "empty both");
        check("empty both count", 32'(count), 32'd1);
        check("empty both rd_data held", 32'(rd_data), 32'h4F);
        step(1'b0, '0, 1'b1, "read 5C");
        check("read 5C", 32'(rd_data), 32'h5C);

        // 40 writes and 40 reads, randomly interleaved, so the pointers
        // wrap at least twice.
        wr_done = 0;
        rd_done = 0;
        budget  = 0;
        max_count = 0;
        while ((wr_done < 40 || rd_done < 40) && budget < 2000) begin
            we = (wr_done < 40) && ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 1) == 1);
            if (we && model_q.size() < DEPTH) wr_done++;
            if (re && model_q.size() > 0)     rd_done++;
            step(we, DATA_W'($urandom), re, "interleave");
            budget++;
        end
        check("interleave finished in budget", 32'(budget < 2000), 32'd1);
        check("count never above DEPTH", 32'(max_count <= DEPTH), 32'd1);

        // Unconstrained random traffic, biased so both boundaries are hit.
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 75 : 25));
            re = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 25 : 75));
            step(we, DATA_W'($urandom), re, "random");
        end

        // Mid-stream reset with 7 words stored.
        do_reset("pre-fill reset");
        for (int i = 0; i < 7; i++) step(1'b1, DATA_W'(8'h70 + i), 1'b0, "fill7");
        check("count 7", 32'(count), 32'd7);
        step(1'b1, 8'hEE, 1'b1, "traffic");
        do_reset("mid reset");
        check("mid reset count", 32'(count), 32'd0);
        check("mid reset empty", 32'(empty), 32'd1);
        step(1'b1, 8'h3C, 1'b0, "write 3C");
        step(1'b0, '0, 1'b1, "read 3C");
        check("post reset 3C", 32'(rd_data), 32'h3C);
        check("post reset empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
